// File: rtl/sdram_client_port_if.sv
// Bundle of client-side request signals and the Avalon-MM master signals to the SDRAM controller.
// The slave modport is the view of sdram_client_port; master is the view of whatever drives it.
interface sdram_client_port_if;
   logic        client_read;
   logic        client_write;
   logic [22:0] client_addr;
   logic [15:0] client_writedata;
   logic [15:0] client_readdata;
   logic        client_finished;
   logic        client_refresh;
   logic        client_err;
   logic [21:0] avm_address;
   logic [3:0]  avm_byteenable;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;
   logic        avm_waitrequest;

   modport slave (
      input  client_read, client_write, client_addr, client_writedata, client_refresh,
      input  avm_readdata, avm_readdatavalid, avm_waitrequest,
      output client_readdata, client_finished, client_err,
      output avm_address, avm_byteenable, avm_read, avm_write, avm_writedata
   );

   modport master (
      output client_read, client_write, client_addr, client_writedata, client_refresh,
      output avm_readdata, avm_readdatavalid, avm_waitrequest,
      input  client_readdata, client_finished, client_err,
      input  avm_address, avm_byteenable, avm_read, avm_write, avm_writedata
   );
endinterface

// File: rtl/sdram_client_port.sv
// Converts 16-bit client read/write requests into single 32-bit Avalon-MM transfers,
// with a one-line write-through read cache and a read-data timeout.
module sdram_client_port #(
   parameter bit          CACHE_EN   = 1'b1,
   parameter int unsigned RD_TIMEOUT = 1023
) (
   input logic                i_clk,
   input logic                i_rst,
   sdram_client_port_if.slave bus
);

   typedef enum logic [2:0] {StIdle, StHit, StWr, StRdCmd, StRdWait, StDone} state_e;

   localparam logic [9:0] TimeoutLast = 10'(RD_TIMEOUT - 1);

   state_e      state_q;
   logic [21:0] addr_q;
   logic        addr0_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;
   logic        rd_q;
   logic        wr_q;
   logic [15:0] rdata_q;
   logic        fin_q;
   logic        err_q;
   logic [31:0] cache_q;
   logic [21:0] tag_q;
   logic        valid_q;
   logic        no_fill_q;
   logic [9:0]  cnt_q;

   logic        req_hit;
   logic        wr_hit;
   logic        timeout;
   logic [15:0] rd_half;

   // A refresh seen together with the request forces a miss.
   assign req_hit = CACHE_EN && valid_q && !bus.client_refresh &&
                    (tag_q == bus.client_addr[22:1]);
   assign wr_hit  = valid_q && (tag_q == addr_q);
   assign timeout = (cnt_q == TimeoutLast);
   assign rd_half = addr0_q ? bus.avm_readdata[31:16] : bus.avm_readdata[15:0];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         addr0_q   <= 1'b0;
         be_q      <= '0;
         wdata_q   <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         rdata_q   <= '0;
         fin_q     <= 1'b0;
         err_q     <= 1'b0;
         cache_q   <= '0;
         tag_q     <= '0;
         valid_q   <= 1'b0;
         no_fill_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         fin_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.client_write) begin
                  addr_q  <= bus.client_addr[22:1];
                  addr0_q <= bus.client_addr[0];
                  be_q    <= bus.client_addr[0] ? 4'b1100 : 4'b0011;
                  wdata_q <= {bus.client_writedata, bus.client_writedata};
                  wr_q    <= 1'b1;
                  state_q <= StWr;
               end else if (bus.client_read) begin
                  addr_q    <= bus.client_addr[22:1];
                  addr0_q   <= bus.client_addr[0];
                  be_q      <= 4'b1111;
                  no_fill_q <= 1'b0;
                  if (req_hit) begin
                     state_q <= StHit;
                  end else begin
                     rd_q    <= 1'b1;
                     state_q <= StRdCmd;
                  end
               end
            end
            StHit: begin
               rdata_q <= addr0_q ? cache_q[31:16] : cache_q[15:0];
               fin_q   <= 1'b1;
               state_q <= StDone;
            end
            StWr: begin
               if (!bus.avm_waitrequest) begin
                  wr_q    <= 1'b0;
                  fin_q   <= 1'b1;
                  state_q <= StDone;
                  if (wr_hit) begin
                     if (addr0_q) cache_q[31:16] <= wdata_q[15:0];
                     else         cache_q[15:0]  <= wdata_q[15:0];
                  end
               end
            end
            StRdCmd: begin
               if (!bus.avm_waitrequest) begin
                  rd_q    <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= StRdWait;
               end
            end
            StRdWait: begin
               if (bus.avm_readdatavalid) begin
                  cache_q <= bus.avm_readdata;
                  tag_q   <= addr_q;
                  valid_q <= !no_fill_q;
                  rdata_q <= rd_half;
                  fin_q   <= 1'b1;
                  state_q <= StDone;
               end else if (timeout) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  fin_q   <= 1'b1;
                  state_q <= StDone;
               end else begin
                  cnt_q <= cnt_q + 10'd1;
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase

         // Refresh overrides any fill above; an in-flight read must not revalidate the line.
         if (bus.client_refresh) begin
            valid_q <= 1'b0;
            if (state_q == StRdCmd || state_q == StRdWait) no_fill_q <= 1'b1;
         end
      end
   end

   assign bus.client_readdata = rdata_q;
   assign bus.client_finished = fin_q;
   assign bus.client_err      = err_q;
   assign bus.avm_address     = addr_q;
   assign bus.avm_byteenable  = be_q;
   assign bus.avm_read        = rd_q;
   assign bus.avm_write       = wr_q;
   assign bus.avm_writedata   = wdata_q;

endmodule

// File: tb/tb_sdram_client_port.sv
// Directed bench for sdram_client_port: writes, cache miss/hit, write-through,
// refresh during fill, read timeout, write priority and reset mid-transaction.
module tb_sdram_client_port;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   sdram_client_port_if bus ();

   sdram_client_port #(
      .CACHE_EN   (1'b1),
      .RD_TIMEOUT (8)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.client_read       = 1'b0;
      bus.client_write      = 1'b0;
      bus.client_addr       = '0;
      bus.client_writedata  = '0;
      bus.client_refresh    = 1'b0;
      bus.avm_readdata      = '0;
      bus.avm_readdatavalid = 1'b0;
      bus.avm_waitrequest   = 1'b1;
      tick();
      tick();
      check_eq("rst_finished", 32'(bus.client_finished), 32'd0);
      check_eq("rst_readdata", 32'(bus.client_readdata), 32'h0);
      check_eq("rst_err",      32'(bus.client_err), 32'd0);
      check_eq("rst_rdwr",     {30'd0, bus.avm_read, bus.avm_write}, 32'd0);
      rst = 1'b0;
      tick();

      // 1: write 0x000005 / BEEF with waitrequest held for 3 cycles
      bus.client_write     = 1'b1;
      bus.client_addr      = 23'h000005;
      bus.client_writedata = 16'hBEEF;
      tick();
      check_eq("t1_avm_write", 32'(bus.avm_write), 32'd1);
      check_eq("t1_address",   32'(bus.avm_address), 32'h2);
      check_eq("t1_be",        32'(bus.avm_byteenable), 32'b1100);
      check_eq("t1_wdata",     bus.avm_writedata, 32'hBEEFBEEF);
      for (int i = 0; i < 3; i++) begin
         check_eq("t1_hold_write", 32'(bus.avm_write), 32'd1);
         check_eq("t1_no_fin",     32'(bus.client_finished), 32'd0);
         tick();
      end
      bus.avm_waitrequest = 1'b0;
      bus.client_write    = 1'b0;
      tick();
      check_eq("t1_fin",        32'(bus.client_finished), 32'd1);
      check_eq("t1_write_drop", 32'(bus.avm_write), 32'd0);
      tick();
      check_eq("t1_fin_pulse",  32'(bus.client_finished), 32'd0);

      // 2: read miss 0x10, data 4 cycles after accept; then hit on 0x11
      bus.client_read = 1'b1;
      bus.client_addr = 23'h10;
      tick();
      check_eq("t2_avm_read", 32'(bus.avm_read), 32'd1);
      check_eq("t2_address",  32'(bus.avm_address), 32'h8);
      check_eq("t2_be",       32'(bus.avm_byteenable), 32'b1111);
      tick();
      check_eq("t2_read_drop", 32'(bus.avm_read), 32'd0);
      tick();
      tick();
      bus.avm_readdatavalid = 1'b1;
      bus.avm_readdata      = 32'h1234ABCD;
      tick();
      check_eq("t2_fin",   32'(bus.client_finished), 32'd1);
      check_eq("t2_rdata", 32'(bus.client_readdata), 32'hABCD);
      bus.avm_readdatavalid = 1'b0;
      bus.client_read       = 1'b0;
      tick();
      check_eq("t2_rdata_hold", 32'(bus.client_readdata), 32'hABCD);
      bus.client_read = 1'b1;
      bus.client_addr = 23'h11;
      tick();
      check_eq("t2_hit_no_read", 32'(bus.avm_read), 32'd0);
      check_eq("t2_hit_no_fin",  32'(bus.client_finished), 32'd0);
      tick();
      check_eq("t2_hit_fin",   32'(bus.client_finished), 32'd1);
      check_eq("t2_hit_rdata", 32'(bus.client_readdata), 32'h1234);
      check_eq("t2_hit_read",  32'(bus.avm_read), 32'd0);
      bus.client_read = 1'b0;
      tick();

      // 3: write-through to 0x11, then hit returns the new half
      bus.client_write     = 1'b1;
      bus.client_writedata = 16'h5555;
      tick();
      check_eq("t3_wdata", bus.avm_writedata, 32'h55555555);
      tick();
      check_eq("t3_fin", 32'(bus.client_finished), 32'd1);
      bus.client_write = 1'b0;
      tick();
      bus.client_read = 1'b1;
      tick();
      check_eq("t3_hit_no_read", 32'(bus.avm_read), 32'd0);
      tick();
      check_eq("t3_hit_rdata", 32'(bus.client_readdata), 32'h5555);
      bus.client_read = 1'b0;
      tick();

      // 4: refresh during fill of 0x20; 0x21 must miss
      bus.client_read = 1'b1;
      bus.client_addr = 23'h20;
      tick();
      tick();
      bus.client_refresh = 1'b1;
      tick();
      bus.client_refresh    = 1'b0;
      bus.avm_readdatavalid = 1'b1;
      bus.avm_readdata      = 32'h87654321;
      tick();
      check_eq("t4_rdata", 32'(bus.client_readdata), 32'h4321);
      bus.avm_readdatavalid = 1'b0;
      bus.client_read       = 1'b0;
      tick();
      bus.client_read = 1'b1;
      bus.client_addr = 23'h21;
      tick();
      check_eq("t4_miss_read", 32'(bus.avm_read), 32'd1);
      tick();
      bus.avm_readdatavalid = 1'b1;
      tick();
      check_eq("t4_miss_rdata", 32'(bus.client_readdata), 32'h8765);
      bus.avm_readdatavalid = 1'b0;
      bus.client_read       = 1'b0;
      tick();

      // 5: timeout after 8 cycles in RD_WAIT
      bus.client_read = 1'b1;
      bus.client_addr = 23'h40;
      tick();
      tick();
      for (int i = 0; i < 7; i++) begin
         check_eq("t5_wait_no_fin", 32'(bus.client_finished), 32'd0);
         tick();
      end
      check_eq("t5_wait_no_fin", 32'(bus.client_finished), 32'd0);
      tick();
      check_eq("t5_fin",   32'(bus.client_finished), 32'd1);
      check_eq("t5_rdata", 32'(bus.client_readdata), 32'h0);
      check_eq("t5_err",   32'(bus.client_err), 32'd1);
      bus.client_read = 1'b0;
      tick();
      tick();
      check_eq("t5_err_sticky", 32'(bus.client_err), 32'd1);

      // 6: read+write together -> write only; reset in the middle of WR
      bus.avm_waitrequest  = 1'b1;
      bus.client_read      = 1'b1;
      bus.client_write     = 1'b1;
      bus.client_addr      = 23'h30;
      bus.client_writedata = 16'h1111;
      tick();
      check_eq("t6_write_only", {30'd0, bus.avm_read, bus.avm_write}, 32'b01);
      tick();
      rst = 1'b1;
      tick();
      check_eq("t6_rst_rdwr",  {30'd0, bus.avm_read, bus.avm_write}, 32'd0);
      check_eq("t6_rst_fin",   32'(bus.client_finished), 32'd0);
      check_eq("t6_rst_err",   32'(bus.client_err), 32'd0);
      check_eq("t6_rst_rdata", 32'(bus.client_readdata), 32'h0);
      rst                  = 1'b0;
      bus.client_read      = 1'b0;
      bus.client_write     = 1'b0;
      bus.avm_waitrequest  = 1'b0;
      tick();
      check_eq("t6_no_fin", 32'(bus.client_finished), 32'd0);

      // Cache must have been invalidated by reset
      bus.client_read = 1'b1;
      bus.client_addr = 23'h21;
      tick();
      check_eq("t6_cache_cleared", 32'(bus.avm_read), 32'd1);
      tick();
      bus.avm_readdatavalid = 1'b1;
      bus.avm_readdata      = 32'hA5A55A5A;
      tick();
      check_eq("t6_rdata", 32'(bus.client_readdata), 32'hA5A5);
      bus.avm_readdatavalid = 1'b0;
      bus.client_read       = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
